// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding and
// the default data-memory wait limit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } ctrl_state_t;

    localparam int          DEFAULT_MAX_WAIT = 15;
    localparam logic [15:0] STALL_MAX        = 16'hFFFF;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                    (id_uses_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: stage enables and flushes, redirect
// select, data-memory wait supervision with timeout to HALT.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        pc_sel_redirect,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        bus_err,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state
);

    localparam int              WW        = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);

    ctrl_state_t   state_q;
    logic [WW-1:0] wait_cnt;
    logic          load_use;
    logic          mem_stall;
    logic          run_eval;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign state     = state_q;
    assign mem_stall = mem_req && !dmem_ready;
    // The MEM_WAIT release cycle behaves exactly like a RUN cycle
    assign run_eval  = (state_q == RUN) || ((state_q == MEM_WAIT) && dmem_ready);

    // Memory freeze outranks everything; redirect outranks load-use and fetch miss
    always_comb begin
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        idex_write      = 1'b0;
        exmem_write     = 1'b0;
        pc_sel_redirect = 1'b0;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        exmem_flush     = 1'b0;
        if (state_q == BOOT) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (run_eval && !mem_stall) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            if (ex_redirect) begin
                pc_sel_redirect = 1'b1;
                ifid_flush      = 1'b1;
                idex_flush      = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if ((state_q != BOOT) && !pc_write && (stall_cnt != STALL_MAX))
                stall_cnt <= stall_cnt + 16'd1;
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (mem_stall)
                        state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_q  <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state_q <= HALT;
                            bus_err <= 1'b1;
                        end
                    end
                end
                HALT: state_q <= HALT;
            endcase
        end
    end

endmodule
